// File: rtl/arrow_hit_judge_if.sv
// Raster, frame and button inputs plus scoring outputs of the arrow hit judge.
// The slave modport is the judge; the master modport is whoever feeds it.
interface arrow_hit_judge_if #(
    parameter int CORDW  = 10,
    parameter int SCOREW = 16,
    parameter int COMBOW = 8
);
    logic [CORDW-1:0]  sx_i;
    logic [CORDW-1:0]  sy_i;
    logic              frame_i;
    logic [3:0]        arrow_i;
    logic [3:0]        btn_i;
    logic [SCOREW-1:0] score_o;
    logic [COMBOW-1:0] combo_o;
    logic [3:0]        hit_o;
    logic [3:0]        miss_o;
    logic [3:0]        flash_o;

    modport master (
        output sx_i, sy_i, frame_i, arrow_i, btn_i,
        input  score_o, combo_o, hit_o, miss_o, flash_o
    );

    modport slave (
        input  sx_i, sy_i, frame_i, arrow_i, btn_i,
        output score_o, combo_o, hit_o, miss_o, flash_o
    );
endinterface

// File: rtl/arrow_hit_judge.sv
// Per-lane arrow/target-strip overlap detection and once-per-frame judgement of
// synchronized button presses into score, combo, hit/miss pulses and lane flashes.
module arrow_hit_judge #(
    parameter int CORDW        = 10,
    parameter int ZONE_TOP     = 30,
    parameter int ZONE_BOT     = 80,
    parameter int HIT_POINTS   = 10,
    parameter int SCOREW       = 16,
    parameter int COMBOW       = 8,
    parameter int FLASH_FRAMES = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    arrow_hit_judge_if.slave bus
);
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [CORDW-1:0] ZT = CORDW'(ZONE_TOP);
    localparam logic [CORDW-1:0] ZB = CORDW'(ZONE_BOT);
    localparam logic [31:0] SCORE_MAX = {{(32-SCOREW){1'b0}}, {SCOREW{1'b1}}};
    localparam logic [31:0] COMBO_MAX = {{(32-COMBOW){1'b0}}, {COMBOW{1'b1}}};

    logic [3:0]        r_btn_s1;
    logic [3:0]        r_btn_s2;
    logic [3:0]        r_btn_d;
    logic [3:0]        r_press_ev;
    logic [3:0]        r_ov;
    logic [3:0]        r_press;
    logic [3:0]        r_lock;
    logic [3:0]        r_hit;
    logic [3:0]        r_miss;
    logic [SCOREW-1:0] r_score;
    logic [COMBOW-1:0] r_combo;
    logic [FW-1:0]     r_flash [4];

    logic              w_in_zone;
    logic [3:0]        w_ov_ev;
    logic [3:0]        w_hit;
    logic [3:0]        w_miss;
    logic [2:0]        w_nhits;
    logic [31:0]       w_score_sum;
    logic [31:0]       w_combo_sum;
    logic [SCOREW-1:0] w_score_next;
    logic [COMBOW-1:0] w_combo_next;
    logic [3:0]        w_flash;
    logic              w_unused_sx;

    assign w_unused_sx = ^bus.sx_i;

    assign w_in_zone = (bus.sy_i >= ZT) && (bus.sy_i <= ZB);
    assign w_ov_ev   = bus.arrow_i & {4{w_in_zone}};

    // A locked lane with overlap is still the same arrow: neither hit nor miss.
    assign w_hit  = r_press & r_ov & ~r_lock;
    assign w_miss = r_press & ~r_ov;

    always_comb begin
        w_nhits = '0;
        for (int unsigned l = 0; l < 4; l++) begin
            w_nhits = w_nhits + 3'(w_hit[l]);
        end
    end

    assign w_score_sum  = 32'(r_score) + 32'(w_nhits) * 32'(HIT_POINTS);
    assign w_score_next = (w_score_sum > SCORE_MAX) ? '1 : w_score_sum[SCOREW-1:0];
    assign w_combo_sum  = 32'(r_combo) + 32'(w_nhits);
    assign w_combo_next = (|w_miss) ? COMBOW'(w_nhits)
                        : ((w_combo_sum > COMBO_MAX) ? '1 : w_combo_sum[COMBOW-1:0]);

    always_comb begin
        w_flash = '0;
        for (int unsigned l = 0; l < 4; l++) begin
            w_flash[l] = (r_flash[l] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_btn_s1   <= '0;
            r_btn_s2   <= '0;
            r_btn_d    <= '0;
            r_press_ev <= '0;
            r_ov       <= '0;
            r_press    <= '0;
            r_lock     <= '0;
            r_hit      <= '0;
            r_miss     <= '0;
            r_score    <= '0;
            r_combo    <= '0;
            for (int unsigned l = 0; l < 4; l++) begin
                r_flash[l] <= '0;
            end
        end else begin
            r_btn_s1   <= bus.btn_i;
            r_btn_s2   <= r_btn_s1;
            r_btn_d    <= r_btn_s2;
            r_press_ev <= r_btn_s2 & ~r_btn_d;
            if (bus.frame_i) begin
                // Accumulators reload with this cycle's events so nothing on the frame cycle is lost.
                r_ov    <= w_ov_ev;
                r_press <= r_press_ev;
                r_lock  <= (r_lock | w_hit) & r_ov;
                r_hit   <= w_hit;
                r_miss  <= w_miss;
                r_score <= w_score_next;
                r_combo <= w_combo_next;
                for (int unsigned l = 0; l < 4; l++) begin
                    if (w_hit[l]) begin
                        r_flash[l] <= FW'(FLASH_FRAMES);
                    end else if (r_flash[l] != '0) begin
                        r_flash[l] <= r_flash[l] - 1'b1;
                    end
                end
            end else begin
                r_ov    <= r_ov | w_ov_ev;
                r_press <= r_press | r_press_ev;
                r_hit   <= '0;
                r_miss  <= '0;
            end
        end
    end

    assign bus.score_o = r_score;
    assign bus.combo_o = r_combo;
    assign bus.hit_o   = r_hit;
    assign bus.miss_o  = r_miss;
    assign bus.flash_o = w_flash;
endmodule

// File: doc/arrow_hit_judge.md
Name: arrow_hit_judge

Overview:
- Scoring stage directly downstream of the arrow renderer.
- Consumes the per-pixel arrow hit vector and the raster position, and detects per lane whether an arrow overlapped the target strip during the frame.
- Judges debounced button presses against that overlap once per frame, at the frame pulse.
- Produces score, combo, per-lane hit/miss pulses, and per-lane flash flags for the display mixer.

Parameters:
- CORDW, 10, raster coordinate width.
- ZONE_TOP, 30, first raster row of the target strip (inclusive).
- ZONE_BOT, 80, last raster row of the target strip (inclusive).
- HIT_POINTS, 10, score added per judged hit.
- SCOREW, 16, score width.
- COMBOW, 8, combo counter width.
- FLASH_FRAMES, 8, frames a lane flash stays lit after a hit.

Ports:
- clk_i  in  1  pixel clock.
- reset_i  in  1  synchronous active-high reset.
- sx_i  in  CORDW  current raster x (unused except for width matching; reserved).
- sy_i  in  CORDW  current raster y.
- frame_i  in  1  one-cycle pulse at start of the blanking interval, once per frame.
- arrow_i  in  4  per-pixel arrow flags {left, up, down, right}, valid the same cycle as sy_i.
- btn_i  in  4  debounced buttons {left, up, down, right}, asynchronous to clk_i.
- score_o  out  SCOREW  accumulated score.
- combo_o  out  COMBOW  consecutive-hit count.
- hit_o  out  4  one-cycle per-lane hit pulse.
- miss_o  out  4  one-cycle per-lane miss pulse.
- flash_o  out  4  per-lane flash-active level.

Behaviour:
- Clock and reset: one clock domain (clk_i). Reset is synchronous and active-high on reset_i.
- Reset values:
  - All outputs are 0.
  - Synchronizers, edge registers, ov_q, press_q, lock_q and flash counters are all 0.
  - Reset mid-frame discards all accumulated state. The first frame_i after reset evaluates only events seen since reset.
- Button input path:
  - Each btn_i bit passes through a 2-flop synchronizer, then a rising-edge detector on the synchronized value.
  - A press event is a 0→1 edge of the synchronized button, 3 cycles after btn_i rises.
  - A held button generates exactly one event.
- Per-frame accumulators, per lane l:
  - ov_q[l] sets when arrow_i[l]=1 and ZONE_TOP ≤ sy_i ≤ ZONE_BOT.
  - press_q[l] sets on a press event.
  - Both are sticky until frame_i.
- Evaluation on the frame_i cycle, per lane, using register values before this cycle's update:
  - lock_q[l]=1 and ov_q[l]=1 → ignore: no hit, no miss.
  - press_q & ov_q & ~lock_q → hit; set lock_q[l].
  - press_q & ~ov_q → miss.
  - ov_q[l]=0 → clear lock_q[l]. An arrow scores at most once while it passes the strip.
- Accumulator reload on frame_i:
  - ov_q and press_q load with that cycle's own events (not cleared to 0).
  - A press or overlap on the frame_i cycle counts toward the next frame.
- Outputs, registered, one cycle after frame_i:
  - hit_o and miss_o are high for exactly one cycle, otherwise 0.
  - score_o and combo_o update in the same cycle as the pulses.
- Arithmetic:
  - nhits = popcount(hit) (0..4).
  - score += nhits*HIT_POINTS, saturating at all-ones (no wrap).
  - Any miss sets combo = nhits. Otherwise combo += nhits, saturating at all-ones.
  - Simultaneous hit and miss in one frame therefore yields combo = nhits.
- Flash:
  - Per-lane counter loads FLASH_FRAMES on a hit.
  - Otherwise it decrements by 1 on each frame_i while nonzero.
  - flash_o[l] = (counter≠0).
  - A hit while the lane is flashing reloads the counter.
- Latency: button edge to judgment is bounded by the next frame_i. Judgment to output is 1 cycle.
- Frame boundaries: no frame_i means no evaluation; accumulators simply stay set. Back-to-back frame_i pulses are legal; each is a separate evaluation.

Test Plan:
- Hit: reset; drive arrow_i=4'b1000 at sy=50 for one cycle, press left mid-frame, pulse frame_i → next cycle hit_o=4'b1000, score_o=10, combo_o=1, flash_o=4'b1000.
- Miss: arrow_i=0 all frame, press up, frame_i → miss_o=4'b0100, score unchanged, combo_o=0.
- Lockout: arrow on lane down overlapping 3 consecutive frames, one press per frame → one hit then two ignored frames (no hit, no miss); score=10. Frame with no overlap clears the lock; the next overlap+press hits again (score=20).
- Multi-lane/mixed: after combo=3, same frame hits on left and right plus a miss on up → score +20, combo_o=2, hit_o=4'b1001, miss_o=4'b0100.
- Edge timing: press event landing exactly on the frame_i cycle → not judged this frame; judged at the following frame_i. Held button across 5 frames → one press_q only.
- Saturation/flash/reset: preload score to 65530, 4-lane hit → score_o=65535. flash_o clears after exactly 8 frame_i pulses. Assert reset_i mid-frame with ov_q/press_q set → next frame_i produces no pulses, all outputs 0.
